// File: rtl/instr_fetch_pkg.sv
// Shared processor definitions for the fetch stage: FSM encoding, PC step,
// and the layout and depth of the fetch FIFO.
package instr_fetch_pkg;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } fetch_state_t;

  localparam logic [31:0] INSTR_STEP = 32'd4;
  localparam int          FIFO_DEPTH = 2;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// fetch_fifo: 2-entry FIFO of {pc, instr} pairs with flush; the head entry
// is cleared on reset so the outputs read zero until the first push.
module fetch_fifo
  import instr_fetch_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t din,
  output fetch_entry_t dout,
  output logic         full,
  output logic         empty
);

  fetch_entry_t mem [FIFO_DEPTH];
  logic         wr_ptr;
  logic         rd_ptr;
  logic [1:0]   count;

  assign dout  = mem[rd_ptr];
  assign full  = (count == 2'(FIFO_DEPTH));
  assign empty = (count == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      // a pop in the same cycle has already been consumed by the receiver
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: sequential PC with redirect, 2-deep output FIFO,
// and a sticky fault on misaligned redirects or running past instruction memory.
//
//   state    | meaning
//   ---------+---------------------------------------------------------
//   ST_RUN   | fetching; push {pc, instr} whenever the FIFO has room
//   ST_FAULT | stopped; PC frozen, redirects ignored, FIFO drains; exit on rst
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fault
);

  localparam logic [31:0] IMEM_LIMIT = 32'(IMEM_WORDS * 4);

  fetch_state_t state;
  logic [31:0]  pc;
  logic         full;
  logic         empty;
  logic         pop;
  logic         push;
  logic         flush;
  logic         in_run;
  logic         pc_oob;
  fetch_entry_t head;

  assign imem_addr = pc;
  assign in_run    = (state == ST_RUN);
  assign pc_oob    = (pc >= IMEM_LIMIT);
  assign pop       = out_valid & out_ready;
  assign flush     = in_run & redirect_valid;
  assign push      = in_run & ~redirect_valid & ~pc_oob & (~full | pop);

  assign out_valid = ~empty;
  assign out_pc    = head.pc;
  assign out_instr = head.instr;

  fetch_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   ('{pc: pc, instr: imem_instr}),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_RUN;
      pc    <= RESET_PC;
      fault <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect_valid) begin
            pc <= redirect_pc;
            if (redirect_pc[1:0] != 2'b00) begin
              state <= ST_FAULT;
              fault <= 1'b1;
            end
          end else if (pc_oob) begin
            state <= ST_FAULT;
            fault <= 1'b1;
          end else if (push) begin
            pc <= pc + INSTR_STEP;
          end
        end
        ST_FAULT: begin
          state <= ST_FAULT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: streaming, backpressure, redirect,
// misaligned-redirect fault and end-of-memory fault.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fault;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [32];

  always #5 clk = ~clk;

  assign imem_instr = (imem_addr < 32'd128) ? mem[imem_addr[6:2]] : 32'hdead_beef;

  instr_fetch #(.RESET_PC(32'h0), .IMEM_WORDS(32)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .fault          (fault)
  );

  function automatic logic [31:0] exp_word(input int k);
    case (k)
      0: return 32'h20020014;
      1: return 32'h2003001e;
      2: return 32'h20050000;
      3: return 32'h10a00001;
      4: return 32'h00432820;
      5: return 32'hac050014;
      default: return 32'ha000_0000 | 32'(k);
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    out_ready = 1'b1;
    do_reset();
    tests++;
    if ({out_valid, out_instr, out_pc} !== {1'b0, 32'h0, 32'h0}) begin
      fails++;
      $display("FAIL reset_out: got v=%b pc=%h instr=%h, want v=0 pc=0 instr=0",
               out_valid, out_pc, out_instr);
    end
    tests++;
    if ({imem_addr, fault} !== {32'h0, 1'b0}) begin
      fails++;
      $display("FAIL reset_pc: got addr=%h fault=%b, want addr=0 fault=0", imem_addr, fault);
    end
  endtask

  task automatic test_stream();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      step();
      tests++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * k), exp_word(k)}) begin
        fails++;
        $display("FAIL stream[%0d]: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                 k, out_valid, out_pc, out_instr, 32'(4 * k), exp_word(k));
      end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0;
    step();
    tests++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0, 32'h20020014}) begin
      fails++;
      $display("FAIL bp_first: got v=%b pc=%h instr=%h, want v=1 pc=0 instr=20020014",
               out_valid, out_pc, out_instr);
    end
    for (int c = 0; c < 5; c++) begin
      step();
      tests++;
      if ({out_valid, out_pc, out_instr, imem_addr} !==
          {1'b1, 32'h0, 32'h20020014, 32'h8}) begin
        fails++;
        $display("FAIL bp_hold[%0d]: got v=%b pc=%h instr=%h addr=%h, want v=1 pc=0 instr=20020014 addr=8",
                 c, out_valid, out_pc, out_instr, imem_addr);
      end
    end
    out_ready = 1'b1;
    for (int k = 1; k < 3; k++) begin
      step();
      tests++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * k), exp_word(k)}) begin
        fails++;
        $display("FAIL bp_release[%0d]: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                 k, out_valid, out_pc, out_instr, 32'(4 * k), exp_word(k));
      end
    end
  endtask

  task automatic test_redirect();
    do_reset();
    out_ready = 1'b1;
    repeat (4) step();
    tests++;
    if ({out_valid, out_pc, out_instr} !== {1'b1, 32'hc, 32'h10a00001}) begin
      fails++;
      $display("FAIL redir_pre: got v=%b pc=%h instr=%h, want v=1 pc=c instr=10a00001",
               out_valid, out_pc, out_instr);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    tests++;
    if ({out_valid, imem_addr, fault} !== {1'b0, 32'h10, 1'b0}) begin
      fails++;
      $display("FAIL redir_bubble: got v=%b addr=%h fault=%b, want v=0 addr=10 fault=0",
               out_valid, imem_addr, fault);
    end
    for (int k = 4; k < 6; k++) begin
      step();
      tests++;
      if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(4 * k), exp_word(k)}) begin
        fails++;
        $display("FAIL redir_target[%0d]: got v=%b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                 k, out_valid, out_pc, out_instr, 32'(4 * k), exp_word(k));
      end
    end
  endtask

  task automatic test_misaligned();
    do_reset();
    out_ready = 1'b1;
    repeat (2) step();
    redirect_valid = 1'b1;
    redirect_pc = 32'h6;
    step();
    tests++;
    if ({fault, out_valid, imem_addr} !== {1'b1, 1'b0, 32'h6}) begin
      fails++;
      $display("FAIL misalign_flush: got fault=%b v=%b addr=%h, want fault=1 v=0 addr=6",
               fault, out_valid, imem_addr);
    end
    // a redirect while faulted must be ignored
    redirect_pc = 32'h0;
    for (int c = 0; c < 4; c++) begin
      step();
      redirect_valid = 1'b0;
      tests++;
      if ({fault, out_valid, imem_addr} !== {1'b1, 1'b0, 32'h6}) begin
        fails++;
        $display("FAIL misalign_hold[%0d]: got fault=%b v=%b addr=%h, want fault=1 v=0 addr=6",
                 c, fault, out_valid, imem_addr);
      end
    end
    do_reset();
    tests++;
    if ({fault, out_valid, imem_addr} !== {1'b0, 1'b0, 32'h0}) begin
      fails++;
      $display("FAIL misalign_reset: got fault=%b v=%b addr=%h, want fault=0 v=0 addr=0",
               fault, out_valid, imem_addr);
    end
  endtask

  task automatic test_end_of_mem();
    do_reset();
    out_ready = 1'b1;
    for (int k = 0; k < 32; k++) begin
      step();
      tests++;
      if ({out_valid, out_pc, out_instr, fault} !== {1'b1, 32'(4 * k), exp_word(k), 1'b0}) begin
        fails++;
        $display("FAIL eom_run[%0d]: got v=%b pc=%h instr=%h fault=%b, want v=1 pc=%h instr=%h fault=0",
                 k, out_valid, out_pc, out_instr, fault, 32'(4 * k), exp_word(k));
      end
    end
    for (int c = 0; c < 3; c++) begin
      step();
      tests++;
      if ({out_valid, fault, imem_addr} !== {1'b0, 1'b1, 32'h80}) begin
        fails++;
        $display("FAIL eom_fault[%0d]: got v=%b fault=%b addr=%h, want v=0 fault=1 addr=80",
                 c, out_valid, fault, imem_addr);
      end
    end
    do_reset();
    step();
    tests++;
    if ({out_valid, out_pc, out_instr, fault} !== {1'b1, 32'h0, 32'h20020014, 1'b0}) begin
      fails++;
      $display("FAIL eom_restart: got v=%b pc=%h instr=%h fault=%b, want v=1 pc=0 instr=20020014 fault=0",
               out_valid, out_pc, out_instr, fault);
    end
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = exp_word(i);
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    out_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misaligned();
    test_end_of_mem();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000: PC loaded on reset.
REQ-002 SHALL have parameter IMEM_WORDS, default 32: number of valid instruction words starting at address 0.
REQ-003 SHALL have a single clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 imem_addr  output  32  byte address to instruction memory; word index = imem_addr[31:2].
REQ-007 imem_instr  input  32  instruction word, combinationally valid for imem_addr in the same cycle.
REQ-008 redirect_valid  input  1  branch/jump taken; overrides sequential PC.
REQ-009 redirect_pc  input  32  target byte address.
REQ-010 out_valid  output  1  out_instr/out_pc hold a fetched instruction.
REQ-011 out_ready  input  1  decode accepts; transfer when out_valid && out_ready.
REQ-012 out_instr  output  32  fetched instruction word.
REQ-013 out_pc  output  32  byte address of out_instr.
REQ-014 fault  output  1  sticky; misaligned redirect or PC past IMEM_WORDS.

Function
REQ-015 SHALL hold a PC register and a 2-entry FIFO of {pc, instr} pairs; out_* SHALL present the FIFO head.
REQ-016 imem_addr SHALL equal PC every cycle.
REQ-017 In state RUN, each cycle the FIFO will not be full after this cycle's pop and no redirect is asserted: push {PC, imem_instr} and PC <= PC+4.
REQ-018 When the FIFO is full and there is no pop, PC and FIFO SHALL hold; imem_addr remains stable.
REQ-019 Fetch-to-out latency SHALL be 1 cycle: an instruction pushed at edge N appears on out_* after edge N when the FIFO was empty.
REQ-020 Sustained throughput with out_ready=1 SHALL be one instruction per cycle.
REQ-021 out_* SHALL remain stable while out_valid=1 and out_ready=0.
REQ-022 On redirect_valid=1: flush FIFO, PC <= redirect_pc, no push this cycle; out_valid=0 the next cycle; target instruction on out_* one cycle after that.
REQ-023 A redirect coincident with a handshake SHALL complete the handshake, then flush.
REQ-024 A redirect with redirect_pc[1:0] != 0 SHALL flush, enter FAULT, and set fault.
REQ-025 PC >= IMEM_WORDS*4 in RUN SHALL NOT push; SHALL enter FAULT and set fault; FIFO contents still drain normally.
REQ-026 FSM states: RUN, FAULT; RUN->FAULT per REQ-024/REQ-025; FAULT->RUN only on reset.
REQ-027 In FAULT, no pushes, PC holds, and redirect_valid is ignored.
REQ-028 PC arithmetic SHALL be 32-bit modulo 2^32; FIFO pointers wrap modulo 2.

Reset
REQ-029 On rst=1 at a clock edge: PC=RESET_PC, FIFO empty, state=RUN, fault=0.
REQ-030 After reset: out_valid=0, out_instr=0, out_pc=0; imem_addr=RESET_PC.
REQ-031 Reset mid-operation SHALL discard FIFO contents and override a coincident redirect.

Structure
REQ-032 FSM state encoding, the 4-byte instruction step, and the FIFO depth SHALL reside in the shared processor package.
REQ-033 The 2-entry FIFO SHALL be a sub-module fetch_fifo (push/pop/flush, full/empty, 64-bit entries).

Verification
REQ-034 Reset; memory words 0..5 = 20020014, 2003001e, 20050000, 10a00001, 00432820, ac050014; out_ready=1 -> out_valid from cycle 1, pc 0,4,...,20 with those words on consecutive cycles.
REQ-035 out_ready=0 for 5 cycles after first valid -> out_* held at pc 0 (20020014); FIFO fills with pc 0,4; imem_addr held at 8; release -> pc 0,4,8 in order, no loss or duplication.
REQ-036 Redirect to 16 during the handshake of pc 12 (10a00001) -> pc 12 accepted, one bubble, then pc 16 (00432820), pc 20.
REQ-037 Redirect to 0x6 -> fault=1, out_valid=0 after the flush, imem_addr stays 6 and out_valid stays 0 until rst.
REQ-038 Free run to pc 124 -> pc 124 delivered, then fault=1 with PC=128 and no further valid outputs; rst -> clean restart at 0.
